g3f_monitor: RTL and testbench

G3F_MONITOR -- requirements
Module: g3f_monitor

---
 rtl/g3f_pkg.sv | 42 ++++
 rtl/g3f_edge_sync.sv | 55 +++++
 rtl/g3f_monitor.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_g3f_monitor.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/g3f_pkg.sv
// ---------------------------------------------------------------------------
// g3f_pkg
// Shared types and constants for the three-phase sequence/period monitor.
//   state_t       : monitor FSM states
//   fault_code_t  : sticky fault reason reported on fault_code
//   PH_A/PH_B/PH_C: bit index of each phase within ph_in
//   next_phase()  : phase expected after a given phase for ABC or ACB order
// ---------------------------------------------------------------------------
package g3f_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEEK  = 2'd1,
    ST_TRACK = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_ORDER   = 2'd1,
    FC_SIMUL   = 2'd2,
    FC_TIMEOUT = 2'd3
  } fault_code_t;

  localparam int unsigned NUM_PH = 3;

  localparam logic [1:0] PH_A = 2'd0;
  localparam logic [1:0] PH_B = 2'd1;
  localparam logic [1:0] PH_C = 2'd2;

  // ABC order cycles A->B->C->A; ACB order cycles A->C->B->A.
  function automatic logic [1:0] next_phase(input logic [1:0] cur, input logic acb);
    logic [1:0] nxt;
    case (cur)
      PH_A:    nxt = acb ? PH_C : PH_B;
      PH_B:    nxt = acb ? PH_A : PH_C;
      default: nxt = acb ? PH_B : PH_A;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/g3f_edge_sync.sv
// ---------------------------------------------------------------------------
// g3f_edge_sync
// Two-flop synchronizer for one asynchronous phase input followed by a
// registered rise/fall detector. A rise on d_async shows up as a one-cycle
// pulse on rise three clock edges later (two sync flops + detector flop);
// fall behaves the same way for the falling transition.
// Ports:
//   clk     : clock
//   rst_n   : synchronous active-low reset, clears every flop
//   d_async : asynchronous input
//   rise    : one-cycle pulse per synchronized rising edge
//   fall    : one-cycle pulse per synchronized falling edge
// ---------------------------------------------------------------------------
module g3f_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    meta_d = d_async;
    sync_d = meta_q;
    prev_d = sync_q;
    rise_d = sync_q & ~prev_q;
    fall_d = ~sync_q & prev_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/g3f_monitor.sv
// ---------------------------------------------------------------------------
// g3f_monitor
// Three-phase sequence and period monitor. Each phase is synchronized and
// edge-detected; an FSM (IDLE/SEEK/TRACK/FAULT) learns the phase order from
// the first edge after A, then checks every following edge against the
// expected cyclic order, measures the A-to-A period and declares lock after
// LOCK_CYCLES consecutive periods within +/- 1/8 of the previous one.
// Faults (order error, simultaneous edges, period timeout) are sticky until
// clr_fault is asserted in FAULT.
//
// Optional feature macro: G3F_MON_DUTY_EN
//   defined   -> duty_hi reports the synchronized high time of phase A,
//                updated on each A falling edge, saturating at all-ones
//   undefined -> duty_hi is tied to 0 and no duty logic exists
//
// Parameters:
//   CNT_W       : width of period / duty counters (>= 8)
//   LOCK_CYCLES : consecutive in-tolerance A periods needed for lock (1..15)
// Ports:
//   clk          : clock, all state on rising edge
//   rst_n        : synchronous active-low reset
//   ph_in[2:0]   : asynchronous phases, bit0=A bit1=B bit2=C
//   clr_fault    : clears the sticky fault while in FAULT
//   period       : last measured A-to-A period in clk cycles
//   period_valid : one-cycle pulse when period updates
//   seq_acb      : 0 = ABC order, 1 = ACB order
//   locked       : sequence and period stable
//   fault        : sticky fault flag
//   fault_code   : 0 none, 1 ORDER, 2 SIMUL, 3 TIMEOUT
//   duty_hi      : A high time in cycles (see macro above)
// ---------------------------------------------------------------------------
module g3f_monitor
  import g3f_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned LOCK_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       ph_in,
  input  logic             clr_fault,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             seq_acb,
  output logic             locked,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] duty_hi
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       LOCK_THR = 4'(LOCK_CYCLES);

  // |cur - prev| <= prev/8 ; a zero previous period never qualifies,
  // so the first measured period after start cannot count toward lock.
  function automatic logic in_tol(input logic [CNT_W-1:0] cur,
                                  input logic [CNT_W-1:0] prev);
    logic [CNT_W-1:0] diff;
    diff = (cur >= prev) ? (cur - prev) : (prev - cur);
    return (diff <= (prev >> 3));
  endfunction

  // Phase synchronizers and edge detectors
  logic [NUM_PH-1:0] rise_w;
  logic [NUM_PH-1:0] fall_w;

  for (genvar i = 0; i < NUM_PH; i++) begin : g_ph
    g3f_edge_sync u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .d_async (ph_in[i]),
      .rise    (rise_w[i]),
      .fall    (fall_w[i])
    );
  end

  // Monitor state
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             pv_q, pv_d;
  logic             acb_q, acb_d;
  logic [1:0]       exp_q, exp_d;
  logic [3:0]       lock_cnt_q, lock_cnt_d;
  logic             locked_q, locked_d;
  logic             fault_q, fault_d;
  fault_code_t      code_q, code_d;

  logic             multi_edge;
  logic             any_edge;
  logic [1:0]       edge_idx;
  logic             cnt_sat;
  logic [CNT_W-1:0] cnt_inc;
  logic             go_fault;
  fault_code_t      go_code;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    pv_d       = 1'b0;
    acb_d      = acb_q;
    exp_d      = exp_q;
    lock_cnt_d = lock_cnt_q;
    fault_d    = fault_q;
    code_d     = code_q;
    go_fault   = 1'b0;
    go_code    = FC_NONE;

    multi_edge = (rise_w[PH_A] & rise_w[PH_B]) |
                 (rise_w[PH_A] & rise_w[PH_C]) |
                 (rise_w[PH_B] & rise_w[PH_C]);
    any_edge   = |rise_w;
    // Only meaningful when exactly one edge is present.
    edge_idx   = rise_w[PH_B] ? PH_B : (rise_w[PH_C] ? PH_C : PH_A);
    cnt_sat    = (cnt_q == {CNT_W{1'b1}});
    cnt_inc    = cnt_sat ? cnt_q : (cnt_q + CNT_ONE);

    case (state_q)
      ST_IDLE: begin
        cnt_d      = '0;
        lock_cnt_d = '0;
        if (rise_w[PH_A] && !multi_edge) begin
          state_d = ST_SEEK;
          cnt_d   = CNT_ONE;
        end
      end

      ST_SEEK: begin
        cnt_d = cnt_inc;
        if (multi_edge) begin
          go_fault = 1'b1;
          go_code  = FC_SIMUL;
        end else if (rise_w[PH_B]) begin
          acb_d   = 1'b0;
          exp_d   = next_phase(PH_B, 1'b0);
          state_d = ST_TRACK;
        end else if (rise_w[PH_C]) begin
          acb_d   = 1'b1;
          exp_d   = next_phase(PH_C, 1'b1);
          state_d = ST_TRACK;
        end else if (rise_w[PH_A]) begin
          // A again before any B/C edge: the order cannot be right.
          go_fault = 1'b1;
          go_code  = FC_ORDER;
        end else if (cnt_sat) begin
          go_fault = 1'b1;
          go_code  = FC_TIMEOUT;
        end
      end

      ST_TRACK: begin
        cnt_d = cnt_inc;
        if (multi_edge) begin
          go_fault = 1'b1;
          go_code  = FC_SIMUL;
        end else if (any_edge && (edge_idx != exp_q)) begin
          go_fault = 1'b1;
          go_code  = FC_ORDER;
        end else if (rise_w[PH_A]) begin
          // Expected A edge closes one period and opens the next.
          period_d = cnt_q;
          pv_d     = 1'b1;
          cnt_d    = CNT_ONE;
          exp_d    = next_phase(PH_A, acb_q);
          if (in_tol(cnt_q, period_q)) begin
            lock_cnt_d = (lock_cnt_q == 4'hF) ? lock_cnt_q : (lock_cnt_q + 4'd1);
          end else begin
            lock_cnt_d = '0;
          end
        end else begin
          if (any_edge) begin
            exp_d = next_phase(edge_idx, acb_q);
          end
          if (cnt_sat) begin
            go_fault = 1'b1;
            go_code  = FC_TIMEOUT;
          end
        end
      end

      ST_FAULT: begin
        if (clr_fault) begin
          state_d    = ST_IDLE;
          fault_d    = 1'b0;
          code_d     = FC_NONE;
          cnt_d      = '0;
          lock_cnt_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Only reachable from SEEK/TRACK, so the first fault always wins.
    if (go_fault) begin
      state_d    = ST_FAULT;
      fault_d    = 1'b1;
      code_d     = go_code;
      lock_cnt_d = '0;
    end

    locked_d = (state_d == ST_TRACK) && (lock_cnt_d >= LOCK_THR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      period_q   <= '0;
      pv_q       <= 1'b0;
      acb_q      <= 1'b0;
      exp_q      <= PH_A;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      fault_q    <= 1'b0;
      code_q     <= FC_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      pv_q       <= pv_d;
      acb_q      <= acb_d;
      exp_q      <= exp_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      fault_q    <= fault_d;
      code_q     <= code_d;
    end
  end

`ifdef G3F_MON_DUTY_EN
  // High-time counter restarts at 1 on A rise; value at the A fall is the
  // number of cycles A was high (both edges share the same sync latency).
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic             unused_fall;

  assign unused_fall = ^{fall_w[PH_B], fall_w[PH_C]};

  always_comb begin
    hi_cnt_d = hi_cnt_q;
    duty_d   = duty_q;
    if (rise_w[PH_A]) begin
      hi_cnt_d = CNT_ONE;
    end else if (hi_cnt_q != {CNT_W{1'b1}}) begin
      hi_cnt_d = hi_cnt_q + CNT_ONE;
    end
    if (fall_w[PH_A]) begin
      duty_d = hi_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_cnt_q <= '0;
      duty_q   <= '0;
    end else begin
      hi_cnt_q <= hi_cnt_d;
      duty_q   <= duty_d;
    end
  end

  assign duty_hi = duty_q;
`else
  logic unused_fall;

  assign unused_fall = ^fall_w;
  assign duty_hi     = '0;
`endif

  assign period       = period_q;
  assign period_valid = pv_q;
  assign seq_acb      = acb_q;
  assign locked       = locked_q;
  assign fault        = fault_q;
  assign fault_code   = code_q;

endmodule

// File: tb/tb_g3f_monitor.sv
// ---------------------------------------------------------------------------
// tb_g3f_monitor
// Directed bench for g3f_monitor (CNT_W=10, LOCK_CYCLES=2). A table of
// steady-state waveform scenarios is followed by hand-written sequences for
// order fault, sticky/clear behaviour, simultaneous edges, timeout and
// reset in the middle of tracking.
// ---------------------------------------------------------------------------
module tb_g3f_monitor;

  localparam int CNT_W = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       ph_in;
  logic             clr_fault;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             seq_acb;
  logic             locked;
  logic             fault;
  logic [1:0]       fault_code;
  logic [CNT_W-1:0] duty_hi;

  g3f_monitor #(.CNT_W(CNT_W), .LOCK_CYCLES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ph_in        (ph_in),
    .clr_fault    (clr_fault),
    .period       (period),
    .period_valid (period_valid),
    .seq_acb      (seq_acb),
    .locked       (locked),
    .fault        (fault),
    .fault_code   (fault_code),
    .duty_hi      (duty_hi)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pv_cnt;
  int pv_dbl;
  bit pv_prev;

  typedef struct {
    bit acb;
    int per;
    int n;
    bit clr;
    bit exp_lock;
    int exp_pv;
    int exp_period;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock, then sample #1 after the edge and track period_valid pulses.
  task automatic step();
    @(posedge clk);
    #1;
    if (period_valid) begin
      pv_cnt++;
      if (pv_prev) pv_dbl++;
    end
    pv_prev = period_valid;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    ph_in     = 3'b000;
    clr_fault = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    pv_cnt  = 0;
    pv_dbl  = 0;
    pv_prev = 1'b0;
  endtask

  // One full period starting with the A rise; each phase high per/3 cycles.
  task automatic run_period(input int per, input bit acb);
    int hi, ob, oc;
    hi = per / 3;
    ob = acb ? (2 * per) / 3 : per / 3;
    oc = acb ? per / 3 : (2 * per) / 3;
    for (int t = 0; t < per; t++) begin
      ph_in[0] = (t < hi);
      ph_in[1] = (t >= ob) && (t < ob + hi);
      ph_in[2] = (t >= oc) && (t < oc + hi);
      step();
    end
  endtask

  function automatic int exp_duty(input int per);
`ifdef G3F_MON_DUTY_EN
    return per / 3;
`else
    return 0 * per;
`endif
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".period"}, 32'(period), 0);
    check({tag, ".pv"}, 32'(period_valid), 0);
    check({tag, ".seq"}, 32'(seq_acb), 0);
    check({tag, ".locked"}, 32'(locked), 0);
    check({tag, ".fault"}, 32'(fault), 0);
    check({tag, ".code"}, 32'(fault_code), 0);
    check({tag, ".duty"}, 32'(duty_hi), 0);
  endtask

  initial begin
    int  found;
    bit  lk_prev;
    bit  lk_at;

    //        acb per  n  clr lock pv  period
    tbl[0] = '{0, 300, 3, 0,  0,   2,  300};
    tbl[1] = '{0, 300, 4, 1,  1,   3,  300};
    tbl[2] = '{1, 300, 4, 0,  1,   3,  300};
    tbl[3] = '{0, 200, 5, 0,  1,   4,  200};
    tbl[4] = '{1, 120, 4, 0,  1,   3,  120};

    do_reset();
    check_all_zero("reset");

    // Steady-state scenarios
    for (int v = 0; v < 5; v++) begin
      do_reset();
      clr_fault = tbl[v].clr;
      for (int k = 0; k < tbl[v].n; k++) run_period(tbl[v].per, tbl[v].acb);
      clr_fault = 1'b0;
      check($sformatf("vec%0d.period", v), 32'(period), tbl[v].exp_period);
      check($sformatf("vec%0d.seq", v), 32'(seq_acb), 32'(tbl[v].acb));
      check($sformatf("vec%0d.locked", v), 32'(locked), 32'(tbl[v].exp_lock));
      check($sformatf("vec%0d.pv_count", v), pv_cnt, tbl[v].exp_pv);
      check($sformatf("vec%0d.pv_double", v), pv_dbl, 0);
      check($sformatf("vec%0d.fault", v), 32'(fault), 0);
      check($sformatf("vec%0d.duty", v), 32'(duty_hi), exp_duty(tbl[v].per));
    end

    // Tolerance loss: 300-cycle lock, then a 200-cycle period breaks it
    do_reset();
    for (int k = 0; k < 4; k++) run_period(300, 1'b0);
    check("tol.locked_before", 32'(locked), 1);
    run_period(200, 1'b0);
    run_period(200, 1'b0);
    check("tol.period_new", 32'(period), 200);
    check("tol.locked_drop", 32'(locked), 0);
    run_period(200, 1'b0);
    run_period(200, 1'b0);
    check("tol.relocked", 32'(locked), 1);

    // Order fault: locked ABC, then C rises before B
    do_reset();
    for (int k = 0; k < 4; k++) run_period(300, 1'b0);
    ph_in = 3'b001;
    for (int i = 0; i < 50; i++) step();
    check("order.locked_pre", 32'(locked), 1);
    ph_in   = 3'b101;
    found   = 0;
    lk_prev = 1'b0;
    lk_at   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      lk_prev = locked;
      step();
      if (fault) begin
        found = 1;
        lk_at = locked;
        break;
      end
    end
    check("order.fault_seen", found, 1);
    check("order.locked_before_edge", 32'(lk_prev), 1);
    check("order.locked_same_cycle", 32'(lk_at), 0);
    check("order.code", 32'(fault_code), 1);
    check("order.period_hold", 32'(period), 300);
    // Later SIMUL condition must not overwrite the first fault
    ph_in = 3'b000;
    for (int i = 0; i < 5; i++) step();
    ph_in = 3'b110;
    for (int i = 0; i < 10; i++) step();
    check("order.sticky_code", 32'(fault_code), 1);
    check("order.sticky_fault", 32'(fault), 1);
    clr_fault = 1'b1;
    step();
    clr_fault = 1'b0;
    check("clr.fault", 32'(fault), 0);
    check("clr.code", 32'(fault_code), 0);
    check("clr.period_hold", 32'(period), 300);

    // Simultaneous A+B in IDLE stays IDLE, so no timeout can follow
    ph_in = 3'b000;
    for (int i = 0; i < 5; i++) step();
    ph_in = 3'b011;
    for (int i = 0; i < 1100; i++) step();
    check("idle_simul.fault", 32'(fault), 0);

    // Timeout: A edge only, then frozen inputs
    do_reset();
    ph_in = 3'b001;
    found = 0;
    for (int i = 1; i <= 1100; i++) begin
      step();
      if (fault) begin
        found = i;
        break;
      end
    end
    check("timeout.cycle", found, 1027);
    check("timeout.code", 32'(fault_code), 3);
    check("timeout.period", 32'(period), 0);

    // B and C rise in the same cycle while in SEEK
    do_reset();
    ph_in = 3'b001;
    for (int i = 0; i < 20; i++) step();
    ph_in = 3'b111;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (fault) begin
        found = 1;
        break;
      end
    end
    check("simul.fault_seen", found, 1);
    check("simul.code", 32'(fault_code), 2);

    // Reset for one cycle in the middle of ACB tracking, then relock ABC
    do_reset();
    for (int k = 0; k < 4; k++) run_period(300, 1'b1);
    check("rst_mid.seq_pre", 32'(seq_acb), 1);
    check("rst_mid.locked_pre", 32'(locked), 1);
    ph_in = 3'b001;
    for (int i = 0; i < 30; i++) step();
    rst_n = 1'b0;
    ph_in = 3'b000;
    step();
    rst_n = 1'b1;
    check_all_zero("rst_mid");
    for (int i = 0; i < 10; i++) step();
    pv_cnt = 0;
    for (int k = 0; k < 4; k++) run_period(300, 1'b0);
    check("relock.locked", 32'(locked), 1);
    check("relock.period", 32'(period), 300);
    check("relock.seq", 32'(seq_acb), 0);
    check("relock.pv_count", pv_cnt, 3);
    check("relock.duty", 32'(duty_hi), exp_duty(300));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
